// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and FSM encoding for the instruction-fetch stage
package if_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Redirect targets are forced onto a word boundary; the dropped bits feed misalign_o.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and flush-to-bubble
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);

  // Flush wins over load so a redirect never lets a wrong-path word through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= 32'd0;
      instr <= BUBBLE_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      pc    <= 32'd0;
      instr <= BUBBLE_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_sequencer.sv
// rtl/if_sequencer.sv - fetch-stage controller: PC, IF/ID capture, stall/redirect/halt sequencing
module if_sequencer
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              halt_req_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic              misalign_o,
  output logic              halted_o,
  output logic [31:0]       fetch_cnt
);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] cnt;
  logic        mis;

  logic        take_redirect;
  logic        advance;
  logic        ifid_load;
  logic        ifid_flush;
  logic        misalign_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // A redirect seen while halted keeps the core halted even if the request drops.
  always_comb begin
    state_next = state;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (!redirect_i && halt_req_i) begin
          state_next = HALT;
        end
      end
      HALT: begin
        if (!redirect_i && !halt_req_i) begin
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    take_redirect = 1'b0;
    advance       = 1'b0;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    case (state)
      BOOT: ifid_flush = 1'b1;
      RUN: begin
        if (redirect_i) begin
          take_redirect = 1'b1;
          ifid_flush    = 1'b1;
        end else if (halt_req_i) begin
          ifid_flush = 1'b1;
        end else if (!stall_i) begin
          advance   = 1'b1;
          ifid_load = 1'b1;
        end
      end
      HALT: begin
        ifid_flush    = 1'b1;
        take_redirect = redirect_i;
      end
      default: ifid_flush = 1'b1;
    endcase
  end

  assign misalign_next = take_redirect & (|redirect_pc_i[1:0]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc  <= RESET_PC;
      cnt <= 32'd0;
      mis <= 1'b0;
    end else begin
      mis <= misalign_next;
      if (take_redirect) begin
        pc <= align_pc(redirect_pc_i);
      end else if (advance) begin
        pc <= pc + 32'd4;
      end
      if (advance) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .pc_in   (pc),
    .instr_in(imem_rdata),
    .pc      (if_id_pc),
    .instr   (if_id_instr),
    .valid   (if_id_valid)
  );

  // PCs past the memory size alias silently through truncation.
  assign imem_addr  = pc[ADDR_W+1:2];
  assign pc_o       = pc;
  assign fetch_cnt  = cnt;
  assign misalign_o = mis;
  assign halted_o   = (state == HALT);

endmodule

// File: tb/tb_if_sequencer.sv
// tb/tb_if_sequencer.sv - directed scoreboard bench for if_sequencer
module tb_if_sequencer;
  import if_pkg::*;

  localparam int unsigned AW = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          stall_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          halt_req_i;
  logic [31:0]   pc_o;
  logic [31:0]   if_id_pc;
  logic [31:0]   if_id_instr;
  logic          if_id_valid;
  logic          misalign_o;
  logic          halted_o;
  logic [31:0]   fetch_cnt;

  logic [31:0] mem [0:(1<<AW)-1];
  assign imem_rdata = mem[imem_addr];

  if_sequencer #(
    .ADDR_W   (AW),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .halt_req_i   (halt_req_i),
    .pc_o         (pc_o),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .misalign_o   (misalign_o),
    .halted_o     (halted_o),
    .fetch_cnt    (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  state_t      m_state;
  logic [31:0] m_pc, m_cnt, m_ifpc, m_instr;
  logic        m_valid, m_mis;

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 + i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    m_ifpc  = 32'd0;
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  // One clock: drive inputs, step the reference model, then compare after the edge.
  task automatic cyc(input logic r, input logic st, input logic rd,
                     input logic [31:0] rpc, input logic hr);
    logic        loaded;
    logic [63:0] e;
    rst = r; stall_i = st; redirect_i = rd; redirect_pc_i = rpc; halt_req_i = hr;
    loaded = 1'b0;
    if (!r) begin
      m_pc = 32'd0; m_cnt = 32'd0; m_mis = 1'b0; m_state = BOOT;
      bubble();
    end else begin
      case (m_state)
        BOOT: begin
          bubble(); m_mis = 1'b0; m_state = RUN;
        end
        RUN: begin
          if (rd) begin
            m_pc = {rpc[31:2], 2'b00}; m_mis = |rpc[1:0]; bubble();
          end else if (hr) begin
            m_state = HALT; m_mis = 1'b0; bubble();
          end else if (st) begin
            m_mis = 1'b0;
          end else begin
            exp_q.push_back({m_pc, mem[m_pc[AW+1:2]]});
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1; m_mis = 1'b0;
            loaded = 1'b1;
          end
        end
        default: begin
          bubble();
          if (rd) begin
            m_pc = {rpc[31:2], 2'b00}; m_mis = |rpc[1:0];
          end else begin
            m_mis = 1'b0;
            if (!hr) m_state = RUN;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (loaded) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        m_ifpc = e[63:32]; m_instr = e[31:0]; m_valid = 1'b1;
      end
    end
    chk("pc_o", pc_o, m_pc);
    chk("imem_addr", 32'(imem_addr), 32'(m_pc[AW+1:2]));
    chk("fetch_cnt", fetch_cnt, m_cnt);
    chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    chk("if_id_pc", if_id_pc, m_ifpc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("misalign_o", 32'(misalign_o), 32'(m_mis));
    chk("halted_o", 32'(halted_o), 32'(m_state == HALT));
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i);
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0; halt_req_i = 1'b0;
    m_state = BOOT; m_pc = 32'd0; m_cnt = 32'd0; m_mis = 1'b0;
    bubble();

    // reset held for three clocks, then boot bubble and three fetches
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'd0, 0);
    chk("rst_instr", if_id_instr, 32'h0000_0013);
    cyc(1, 0, 0, 32'd0, 0);
    chk("boot_valid", 32'(if_id_valid), 32'd0);
    cyc(1, 0, 0, 32'd0, 0);
    chk("t1_first_pc", if_id_pc, 32'h0);
    chk("t1_first_instr", if_id_instr, pat(0));
    cyc(1, 0, 0, 32'd0, 0);
    cyc(1, 0, 0, 32'd0, 0);
    chk("t1_cnt", fetch_cnt, 32'd3);
    chk("t1_ifpc", if_id_pc, 32'h8);
    cyc(1, 0, 0, 32'd0, 0);

    // two-cycle stall at pc 0x10
    cyc(1, 1, 0, 32'd0, 0);
    cyc(1, 1, 0, 32'd0, 0);
    chk("t2_pc", pc_o, 32'h10);
    chk("t2_cnt", fetch_cnt, 32'd4);
    chk("t2_ifpc", if_id_pc, 32'h0C);
    cyc(1, 0, 0, 32'd0, 0);
    chk("t2_resume", if_id_pc, 32'h10);

    // redirect wins over a simultaneous stall
    cyc(1, 1, 1, 32'h40, 0);
    chk("t3_pc", pc_o, 32'h40);
    chk("t3_valid", 32'(if_id_valid), 32'd0);
    cyc(1, 0, 0, 32'd0, 0);
    chk("t3_ifpc", if_id_pc, 32'h40);

    // misaligned redirect: one-cycle pulse
    cyc(1, 0, 1, 32'h43, 0);
    chk("t4_pc", pc_o, 32'h40);
    chk("t4_mis", 32'(misalign_o), 32'd1);
    cyc(1, 0, 0, 32'd0, 0);
    chk("t4_mis_clear", 32'(misalign_o), 32'd0);

    // five-cycle halt with a redirect landing inside it
    cyc(1, 0, 0, 32'd0, 1);
    cyc(1, 0, 0, 32'd0, 1);
    cyc(1, 0, 1, 32'h80, 1);
    chk("t5_halted", 32'(halted_o), 32'd1);
    chk("t5_pc", pc_o, 32'h80);
    cyc(1, 0, 0, 32'd0, 1);
    cyc(1, 0, 0, 32'd0, 1);
    cyc(1, 0, 0, 32'd0, 0);
    chk("t5_release", 32'(halted_o), 32'd0);
    cyc(1, 0, 0, 32'd0, 0);
    chk("t5_first", if_id_pc, 32'h80);

    // run to the end of instruction memory and past it
    for (int i = 0; i < 2000 && m_pc != 32'h1000; i++) cyc(1, 0, 0, 32'd0, 0);
    chk("t6_reach", m_pc, 32'h1000);
    chk("t6_wrap_addr", 32'(imem_addr), 32'd0);
    chk("t6_last_instr", if_id_instr, pat((1 << AW) - 1));
    cyc(1, 0, 0, 32'd0, 0);
    chk("t6_alias_pc", if_id_pc, 32'h1000);
    chk("t6_alias_instr", if_id_instr, pat(0));

    // reset mid-stream overrides redirect and halt
    cyc(0, 1, 1, 32'h33, 1);
    chk("t6_rst_pc", pc_o, 32'd0);
    chk("t6_rst_cnt", fetch_cnt, 32'd0);
    chk("t6_rst_mis", 32'(misalign_o), 32'd0);
    cyc(1, 0, 0, 32'd0, 1);
    chk("boot_ignores_halt", 32'(halted_o), 32'd0);
    cyc(1, 0, 0, 32'd0, 0);
    chk("t6_refetch", if_id_pc, 32'h0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
